// File: rtl/beta_dcache_ctrl.sv
// Direct-mapped write-through word cache for Beta loads: hits return data in 0 cycles, misses stall through the MemReadReady/MemReadDone fill.
// Backpressure is the stall output only; define DCACHE_STATS_EN to add saturating hitCount/missCount outputs.
module beta_dcache_ctrl #(
    parameter  int LINES = 16,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] memReadData,
    input  logic        MemReadReady,
    output logic        MemReadDone,
    output logic        MemHit,
    output logic [31:0] cacheReadData,
    output logic        stall
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hitCount,
    output logic [15:0] missCount
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_READY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag [LINES];
    logic [31:0]        r_data [LINES];
    logic [IDX_W-1:0]   r_miss_idx;
    logic [TAG_W-1:0]   r_miss_tag;
    logic [31:0]        r_rdata;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic               w_store;
    logic               w_unused;

    assign w_idx    = memAddr[IDX_W+1:2];
    assign w_tag    = memAddr[31:IDX_W+2];
    assign w_unused = ^memAddr[1:0];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        MemHit      = 1'b0;
        stall       = 1'b0;
        w_miss      = 1'b0;
        w_fill      = 1'b0;
        w_store     = 1'b0;
        case (r_state)
            S_IDLE: begin
                MemHit  = MemRead && w_hit;
                // A simultaneous load wins; the store half is dropped.
                w_store = MemWrite && !MemRead && w_hit;
                if (MemRead && !w_hit) begin
                    stall       = 1'b1;
                    w_miss      = 1'b1;
                    w_state_nxt = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                stall = 1'b1;
                if (MemReadReady) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                stall = MemReadReady;
                if (!MemReadReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign MemReadDone   = (r_state == S_DONE);
    assign cacheReadData = MemHit ? r_data[w_idx] : r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_miss_idx <= '0;
            r_miss_tag <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_miss) begin
                r_miss_idx <= w_idx;
                r_miss_tag <= w_tag;
            end
            if (w_fill) begin
                r_valid[r_miss_idx] <= 1'b1;
                r_rdata             <= memReadData;
            end
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_data[r_miss_idx] <= memReadData;
        end else if (w_store) begin
            r_data[w_idx] <= memWriteData;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (MemHit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hitCount  = r_hit_cnt;
    assign missCount = r_miss_cnt;
`endif

endmodule

// File: tb/tb_beta_dcache_ctrl.sv
// Directed bench for beta_dcache_ctrl: cycle-by-cycle vector table plus reset-mid-miss and stats sequences.
module tb_beta_dcache_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] memReadData;
    logic        MemReadReady;
    logic        MemReadDone;
    logic        MemHit;
    logic [31:0] cacheReadData;
    logic        stall;
`ifdef DCACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    int checks;
    int failures;

    beta_dcache_ctrl #(.LINES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .memAddr       (memAddr),
        .memWriteData  (memWriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .memReadData   (memReadData),
        .MemReadReady  (MemReadReady),
        .MemReadDone   (MemReadDone),
        .MemHit        (MemHit),
        .cacheReadData (cacheReadData),
        .stall         (stall)
`ifdef DCACHE_STATS_EN
        ,
        .hitCount      (hitCount),
        .missCount     (missCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] mdata;
        logic        e_hit;
        logic        e_stall;
        logic        e_done;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic h, input logic s, input logic d,
                            input logic [31:0] data);
        chk({tag, ".MemHit"}, {31'd0, MemHit}, {31'd0, h});
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
        chk({tag, ".MemReadDone"}, {31'd0, MemReadDone}, {31'd0, d});
        chk({tag, ".cacheReadData"}, cacheReadData, data);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy, input logic [31:0] mdata);
        @(posedge clk);
        #1;
        MemRead      = rd;
        MemWrite     = wr;
        memAddr      = addr;
        memWriteData = wdata;
        MemReadReady = rdy;
        memReadData  = mdata;
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rdy, input logic [31:0] mdata,
                       input logic h, input logic s, input logic d, input logic [31:0] data);
        vecs.push_back('{rd, wr, addr, wdata, rdy, mdata, h, s, d, data});
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        MemReadReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

`ifdef DCACHE_STATS_EN
    // Miss then fill: IDLE miss, WAIT with ready, DONE with ready low.
    task automatic fill_load(input logic [31:0] addr, input logic [31:0] mdata);
        drive(1'b1, 1'b0, addr, 32'd0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, addr, 32'd0, 1'b1, mdata);
        drive(1'b0, 1'b0, addr, 32'd0, 1'b0, 32'd0);
    endtask
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        memAddr      = 32'd0;
        memWriteData = 32'd0;
        memReadData  = 32'd0;
        MemReadReady = 1'b0;

        //   rd wr addr          wdata         rdy mdata         hit stl done data
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        1, 32'h1234_5678, 0, 1, 0, 32'h0);
        add(1, 0, 32'h0000_0040, 32'h0,        1, 32'h1234_5678, 0, 1, 1, 32'h1234_5678);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 0, 1, 32'h1234_5678);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        1, 32'hB0B0_B0B0, 0, 1, 0, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        0, 32'h0,        0, 0, 1, 32'hB0B0_B0B0);
        add(1, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 1, 0, 32'hB0B0_B0B0);
        add(0, 0, 32'h0000_0040, 32'h0,        1, 32'h1234_5678, 0, 1, 0, 32'hB0B0_B0B0);
        add(0, 0, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 0, 1, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        1, 32'hCAFE_F00D, 0, 1, 0, 32'h1234_5678);
        add(1, 0, 32'h0000_0080, 32'h0,        0, 32'h0,        0, 0, 1, 32'hCAFE_F00D);
        add(0, 1, 32'h0000_0080, 32'hDEAD_BEEF, 0, 32'h0,       0, 0, 0, 32'hCAFE_F00D);
        add(1, 0, 32'h0000_0080, 32'h0,        0, 32'h0,        1, 0, 0, 32'hDEAD_BEEF);
        add(0, 1, 32'h0000_0100, 32'h1111_1111, 0, 32'h0,       0, 0, 0, 32'hCAFE_F00D);
        add(1, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        0, 1, 0, 32'hCAFE_F00D);
        add(1, 0, 32'h0000_0100, 32'h0,        1, 32'h2222_2222, 0, 1, 0, 32'hCAFE_F00D);
        add(1, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        0, 0, 1, 32'h2222_2222);
        add(1, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 0, 0, 32'h2222_2222);
        add(1, 1, 32'h0000_0100, 32'h3333_3333, 0, 32'h0,       1, 0, 0, 32'h2222_2222);
        add(1, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 0, 0, 32'h2222_2222);
        add(0, 0, 32'h0000_0100, 32'h0,        1, 32'h4444_4444, 0, 0, 0, 32'h2222_2222);
        add(1, 0, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 0, 0, 32'h2222_2222);

        // Reset values while reset is held low.
        @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].mdata);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_stall, vecs[i].e_done,
                     vecs[i].e_data);
        end

        // Reset while waiting for memory; the pending fill must be discarded.
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_outs("wait_pre_rst", 1'b0, 1'b1, 1'b0, 32'h2222_2222);
        #1;
        reset        = 1'b0;
        MemReadReady = 1'b1;
        memReadData  = 32'h5555_5555;
        #1;
        chk_outs("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk_outs("mid_rst_edge", 1'b0, 1'b0, 1'b0, 32'h0);
        reset        = 1'b1;
        MemReadReady = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_outs("post_rst_load", 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'h6666_6666);
        drive(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_outs("post_rst_done", 1'b0, 1'b0, 1'b1, 32'h6666_6666);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_outs("old_line_gone", 1'b0, 1'b1, 1'b0, 32'h6666_6666);
        drive(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h7777_7777);
        drive(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk_outs("idx1_kept", 1'b1, 1'b0, 1'b0, 32'h6666_6666);

`ifdef DCACHE_STATS_EN
        do_reset();
        @(negedge clk);
        chk("hitCount_rst", {16'd0, hitCount}, 32'd0);
        chk("missCount_rst", {16'd0, missCount}, 32'd0);
        fill_load(32'h0000_0040, 32'hA0A0_A0A0);
        fill_load(32'h0000_0044, 32'hA1A1_A1A1);
        fill_load(32'h0000_0048, 32'hA2A2_A2A2);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("missCount", {16'd0, missCount}, 32'd3);
        chk("hitCount", {16'd0, hitCount}, 32'd4);
        force dut.r_hit_cnt = 16'hFFFF;
        #1;
        release dut.r_hit_cnt;
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hitCount_sat", {16'd0, hitCount}, 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beta_dcache_ctrl.md
Name: beta_dcache_ctrl

Overview:
- Read-side data-memory controller inside the Beta. Holds a direct-mapped, write-through, no-write-allocate word cache.
- Answers datapath loads in the same cycle on a hit (MemHit). On a miss it stalls the Beta and runs the MemReadReady/MemReadDone handshake with the slow external data memory.
- It then fills the line and releases the pipeline. It sits between the Beta's memAddr/MemRead/MemWrite outputs and the external dmem.

Parameters:
- LINES, 16, number of one-word cache lines; power of 2, minimum 2.
- IDX_W, $clog2(LINES), index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memAddr  in  32  byte address from datapath.
- memWriteData  in  32  store data from datapath.
- MemRead  in  1  datapath load request.
- MemWrite  in  1  datapath store request.
- memReadData  in  32  word from external memory; valid while MemReadReady=1.
- MemReadReady  in  1  external memory has data ready.
- MemReadDone  out  1  controller has captured memReadData.
- MemHit  out  1  current load hits in cache.
- cacheReadData  out  32  load data to datapath.
- stall  out  1  freeze PC/pipeline this cycle.

Behaviour:
- Address split: index = memAddr[IDX_W+1:2]; tag = memAddr[31:IDX_W+2]; memAddr[1:0] ignored.
- Storage per line: valid bit, tag, 32-bit data.
- Reset (reset=0, async):
  - All valid bits cleared.
  - State IDLE.
  - MemReadDone=0, stall=0, MemHit=0, cacheReadData=0.
  - Applies at any point, including mid-miss. Any pending fill is discarded and no line is written.
- FSM states: IDLE, WAIT_READY, DONE.
- IDLE:
  - MemHit = MemRead & valid[index] & (tag match), combinational.
  - On a hit, cacheReadData = line data, stall=0, and the load completes in 0 extra cycles.
  - On MemRead & !hit: stall=1 combinationally, next state WAIT_READY, and memAddr is latched into an internal miss-address register.
  - MemReadReady in IDLE is ignored.
- WAIT_READY:
  - stall=1, MemHit=0.
  - Waits indefinitely for MemReadReady=1.
  - On the rising edge where MemReadReady=1: write memReadData into the line at the latched index, set valid and tag, register cacheReadData=memReadData, assert MemReadDone, go to DONE.
- DONE:
  - MemReadDone=1 and cacheReadData held.
  - While MemReadReady=1: stall=1.
  - In the first cycle with MemReadReady=0: stall=0 (the Beta retires the load with the filled data), MemReadDone stays 1 for that cycle, next state IDLE.
  - MemReadDone clears on the IDLE entry edge.
- Stores:
  - Write-through. In IDLE with MemWrite=1 and the line valid with a matching tag, the line data is updated with memWriteData on the clock edge. No allocate on a store miss.
  - MemHit is never asserted for stores.
  - Stores never stall.
- Simultaneous MemRead and MemWrite: treated as a load; the store update is suppressed.
- MemRead dropping while in WAIT_READY or DONE: the handshake still completes and the line is filled.
- Same-index different-tag load evicts the old line; there is no replacement state.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hitCount[15:0] and missCount[15:0].
  - hitCount increments on each IDLE cycle with MemHit=1.
  - missCount increments on each IDLE→WAIT_READY transition.
  - Both counters are saturating at 16'hFFFF and cleared by reset.
- When undefined: these ports and counters do not exist, and the behaviour of the block is otherwise identical.

Test Plan:
- Reset then load 0x0000_0040, memory returns 0x1234_5678 after 5 cycles: MemHit=0, stall=1 until the cycle after MemReadReady falls, MemReadDone=1 through that cycle, cacheReadData=0x1234_5678.
- Repeat load 0x0000_0040: MemHit=1 the same cycle, stall=0, cacheReadData=0x1234_5678, no handshake.
- Load 0x0000_0080 (same index when LINES=16, different tag): miss. Then reload 0x0000_0040: miss again (eviction).
- Store 0xDEAD_BEEF to cached 0x0000_0080, then load 0x0000_0080: hit, returns 0xDEAD_BEEF. Store to an uncached 0x0000_0100 followed by a load: miss.
- Assert reset low while in WAIT_READY, then release and load the same address: state IDLE, MemReadDone=0, stall=0 during reset; the load after release misses (line not valid).
- With DCACHE_STATS_EN defined, run 3 misses and 4 hits: missCount=3, hitCount=4. Force hitCount to 0xFFFF and hit again: count stays 0xFFFF.
